// File: rtl/ram_bridge_pkg.sv
// Shared types and defaults for the CPU-to-DDR ram request bridge.
package ram_bridge_pkg;
   localparam int DEF_TIMEOUT_CYCLES = 4096;
   localparam int DEF_RAM_AW         = 29;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_WR_ISSUE,
      ST_RD_ISSUE,
      ST_RD_WAIT
   } bridge_state_e;
endpackage

// File: rtl/ram_req_bridge_if.sv
// CPU data-port and ram request-port bundles used by ram_req_bridge.
interface cpu_req_if;
   logic        cpu_en;
   logic        cpu_we;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic        cpu_stall;
   logic [31:0] cpu_rdata;
   logic        cpu_rvalid;
   logic        cpu_err;

   modport master (
      output cpu_en, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_stall, cpu_rdata, cpu_rvalid, cpu_err
   );
   modport slave (
      input  cpu_en, cpu_we, cpu_addr, cpu_wdata,
      output cpu_stall, cpu_rdata, cpu_rvalid, cpu_err
   );
endinterface

interface ram_port_if #(parameter int RAM_AW = ram_bridge_pkg::DEF_RAM_AW);
   logic [RAM_AW-1:0] ram_addr;
   logic [31:0]       ram_wdata;
   logic              ram_read_req;
   logic              ram_write_req;
   logic              ram_write_ready;
   logic              ram_read_ready;
   logic              ram_stall;
   logic              ram_read_data_valid;
   logic [31:0]       ram_read_data;
   logic              init_calib_complete;

   modport master (
      output ram_addr, ram_wdata, ram_read_req, ram_write_req,
      input  ram_write_ready, ram_read_ready, ram_stall,
             ram_read_data_valid, ram_read_data, init_calib_complete
   );
   modport slave (
      input  ram_addr, ram_wdata, ram_read_req, ram_write_req,
      output ram_write_ready, ram_read_ready, ram_stall,
             ram_read_data_valid, ram_read_data, init_calib_complete
   );
endinterface

// File: rtl/ram_req_bridge.sv
// ram_req_bridge: one-outstanding-request bridge from a CPU data port to a
// DDR ram controller, stalling the CPU while calibrating, issuing or waiting.
module ram_req_bridge
   import ram_bridge_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int RAM_AW         = DEF_RAM_AW
) (
   input  logic          clk,
   input  logic          rst_n,
   cpu_req_if.slave      cpu,
   ram_port_if.master    ram,
   output bridge_state_e state_dbg
);
   localparam int               CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   bridge_state_e     state_q, state_d;
   logic [RAM_AW-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       rdata_q;
   logic              rvalid_q;
   logic              err_q;
   logic [CNT_W-1:0]  cnt_q;

   logic accept, addr_oor, abort, rd_done, rd_timeout, wr_req, rd_req;

   // Handshake: a request is offered (req=1) whenever its ISSUE state is active
   // and ram_stall is low, independent of ready; it is taken on the first cycle
   // where req=1, the matching ready=1 and ram_stall=0, and held until then.
   always_comb begin
      state_d    = state_q;
      accept     = 1'b0;
      addr_oor   = 1'b0;
      abort      = 1'b0;
      rd_done    = 1'b0;
      rd_timeout = 1'b0;
      wr_req     = 1'b0;
      rd_req     = 1'b0;
      case (state_q)
         ST_INIT: begin
            if (ram.init_calib_complete) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (!ram.init_calib_complete) begin
               state_d = ST_INIT;
            end else if (cpu.cpu_en) begin
               accept = 1'b1;
               if (cpu.cpu_addr[31:RAM_AW] != '0) addr_oor = 1'b1;
               else state_d = cpu.cpu_we ? ST_WR_ISSUE : ST_RD_ISSUE;
            end
         end
         ST_WR_ISSUE: begin
            wr_req = ~ram.ram_stall;
            if (!ram.init_calib_complete) begin
               abort   = 1'b1;
               state_d = ST_INIT;
            end else if (wr_req && ram.ram_write_ready) begin
               state_d = ST_IDLE;
            end
         end
         ST_RD_ISSUE: begin
            rd_req = ~ram.ram_stall;
            if (!ram.init_calib_complete) begin
               abort   = 1'b1;
               state_d = ST_INIT;
            end else if (rd_req && ram.ram_read_ready) begin
               state_d = ST_RD_WAIT;
            end
         end
         ST_RD_WAIT: begin
            // Returned data beats a timeout landing on the same cycle.
            if (!ram.init_calib_complete) begin
               abort   = 1'b1;
               state_d = ST_INIT;
            end else if (ram.ram_read_data_valid) begin
               rd_done = 1'b1;
               state_d = ST_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               rd_timeout = 1'b1;
               state_d    = ST_IDLE;
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_INIT;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         rvalid_q <= rd_done;
         err_q    <= addr_oor | abort | rd_timeout;
         if (accept) begin
            addr_q  <= cpu.cpu_addr[RAM_AW-1:0];
            wdata_q <= cpu.cpu_wdata;
         end
         if (rd_done)         rdata_q <= ram.ram_read_data;
         else if (rd_timeout) rdata_q <= '0;
         // Counter sits at zero outside RD_WAIT so every entry starts fresh.
         if (state_q == ST_RD_WAIT) cnt_q <= cnt_q + 1'b1;
         else                       cnt_q <= '0;
      end
   end

   assign ram.ram_addr      = addr_q;
   assign ram.ram_wdata     = wdata_q;
   assign ram.ram_write_req = wr_req;
   assign ram.ram_read_req  = rd_req;
   assign cpu.cpu_stall     = (state_q != ST_IDLE);
   assign cpu.cpu_rdata     = rdata_q;
   assign cpu.cpu_rvalid    = rvalid_q;
   assign cpu.cpu_err       = err_q;
   assign state_dbg         = state_q;
endmodule

// File: tb/tb_ram_req_bridge.sv
// Bench for ram_req_bridge: directed vector table, randomized transactions
// against a memory-level reference model, and calibration/reset sequences.
module tb_ram_req_bridge;
   import ram_bridge_pkg::*;

   localparam int TO = 16;
   localparam int AW = 29;
   localparam int W  = 34;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   cpu_req_if cpu ();
   ram_port_if #(.RAM_AW(AW)) ram ();
   bridge_state_e state_dbg;

   ram_req_bridge #(.TIMEOUT_CYCLES(TO), .RAM_AW(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cpu       (cpu),
      .ram       (ram),
      .state_dbg (state_dbg)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   int n_vec  = 0;
   int n_miss = 0;
   logic [W-1:0] exp_q[$];
   logic [31:0] ram_mem [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          stall;
      int          rdy;
      int          lat;
      logic [31:0] rd_val;
      int          x_end;
      bit          x_err;
      bit          x_rvalid;
      logic [31:0] x_rdata;
      int          x_hs;
   } vec_t;

   typedef struct {
      int          end_c;
      bit          err;
      bit          rvalid;
      logic [31:0] rdata;
      int          n_hs;
      int          hs_c;
      logic [31:0] hs_addr;
      logic [31:0] hs_wdata;
      int          stall_reqs;
      int          both_reqs;
   } res_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic ram_idle();
      ram.ram_stall           = 1'b0;
      ram.ram_write_ready     = 1'b1;
      ram.ram_read_ready      = 1'b1;
      ram.ram_read_data_valid = 1'b0;
      ram.ram_read_data       = 32'h0;
   endtask

   task automatic recover();
      rst_n = 1'b0;
      ram_idle();
      cpu.cpu_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
   endtask

   // Called just after a negedge with the bridge idle. Plays the CPU for the
   // accept cycle and the ram for the rest; cycle 1 is the first after accept.
   task automatic run_txn(input vec_t v, input bit use_mem, output res_t r);
      logic [31:0] rv;
      logic [31:0] k;
      r  = '{default: 0};
      rv = v.rd_val;
      cpu.cpu_en    = 1'b1;
      cpu.cpu_we    = v.we;
      cpu.cpu_addr  = v.addr;
      cpu.cpu_wdata = v.wdata;
      @(negedge clk);
      cpu.cpu_en = 1'b0;
      for (int c = 1; c <= 80; c++) begin
         if (cpu.cpu_rvalid) begin r.rvalid = 1'b1; r.rdata = cpu.cpu_rdata; end
         if (cpu.cpu_err)    begin r.err = 1'b1;    r.rdata = cpu.cpu_rdata; end
         if (!cpu.cpu_stall) begin r.end_c = c; break; end
         ram.ram_stall           = (c <= v.stall);
         ram.ram_write_ready     = (c > v.rdy);
         ram.ram_read_ready      = (c > v.rdy);
         ram.ram_read_data_valid = (v.lat > 0) && (r.n_hs > 0) && (c == r.hs_c + v.lat);
         ram.ram_read_data       = ram.ram_read_data_valid ? rv : $urandom();
         #1;
         if (ram.ram_read_req && ram.ram_write_req) r.both_reqs++;
         if (ram.ram_stall && (ram.ram_read_req || ram.ram_write_req)) r.stall_reqs++;
         if (!ram.ram_stall && ((ram.ram_write_req && ram.ram_write_ready) ||
                                (ram.ram_read_req && ram.ram_read_ready))) begin
            r.n_hs++;
            r.hs_c     = c;
            r.hs_addr  = {3'b000, ram.ram_addr};
            r.hs_wdata = ram.ram_wdata;
            k = {3'b000, ram.ram_addr};
            if (use_mem && ram.ram_write_req) ram_mem[k] = ram.ram_wdata;
            if (use_mem && ram.ram_read_req) rv = ram_mem.exists(k) ? ram_mem[k] : init_word(k);
         end
         @(negedge clk);
      end
      ram_idle();
      if (r.end_c == 0) recover();
   endtask

   task automatic check_vec(input string tag, input vec_t v, input res_t r);
      logic [W-1:0] act;
      act = {r.err, r.rvalid, (r.rvalid || (r.err && r.n_hs > 0)) ? r.rdata : 32'h0};
      check({tag, " response"}, act, exp_q.pop_front());
      check({tag, " idle_cycle"}, r.end_c, v.x_end);
      check({tag, " handshakes"}, r.n_hs, v.x_hs);
      check({tag, " req_in_stall"}, r.stall_reqs, 0);
      check({tag, " both_reqs"}, r.both_reqs, 0);
      if (v.x_hs > 0) check({tag, " ram_addr"}, r.hs_addr, {3'b000, v.addr[28:0]});
      if (v.x_hs > 0 && v.we) check({tag, " ram_wdata"}, r.hs_wdata, v.wdata);
   endtask

   // ---------------- test ----------------
   vec_t tv[10];
   vec_t rvec;
   res_t res;
   int   hs;

   initial begin
      // we addr wdata stall rdy lat rd_val | end err rvalid rdata hs
      tv[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0, 0,  32'h0,         2,  1'b0, 1'b0, 32'h0,         1};
      tv[1] = '{1'b0, 32'h0000_0040, 32'h0,         5, 0, 7,  32'h1234_5678, 14, 1'b0, 1'b1, 32'h1234_5678, 1};
      tv[2] = '{1'b0, 32'h7000_0000, 32'h0,         0, 0, 0,  32'h0,         1,  1'b1, 1'b0, 32'h0,         0};
      tv[3] = '{1'b0, 32'h0000_0044, 32'h0,         0, 0, 0,  32'h0,         18, 1'b1, 1'b0, 32'h0,         1};
      tv[4] = '{1'b1, 32'h1FFF_FFFC, 32'h0123_4567, 3, 0, 0,  32'h0,         5,  1'b0, 1'b0, 32'h0,         1};
      tv[5] = '{1'b1, 32'h2000_0000, 32'h5555_AAAA, 0, 0, 0,  32'h0,         1,  1'b1, 1'b0, 32'h0,         0};
      tv[6] = '{1'b0, 32'h0000_0048, 32'h0,         0, 0, 16, 32'hCAFE_F00D, 18, 1'b0, 1'b1, 32'hCAFE_F00D, 1};
      tv[7] = '{1'b0, 32'h0000_004C, 32'h0,         0, 2, 1,  32'h0BAD_F00D, 5,  1'b0, 1'b1, 32'h0BAD_F00D, 1};
      tv[8] = '{1'b1, 32'h0000_0020, 32'hA5A5_A5A5, 1, 4, 0,  32'h0,         6,  1'b0, 1'b0, 32'h0,         1};
      tv[9] = '{1'b0, 32'h0000_0050, 32'h0,         2, 0, 0,  32'h0,         20, 1'b1, 1'b0, 32'h0,         1};

      cpu.cpu_en = 1'b0; cpu.cpu_we = 1'b0; cpu.cpu_addr = '0; cpu.cpu_wdata = '0;
      ram_idle();
      ram.init_calib_complete = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst stall", cpu.cpu_stall, 1);
      check("rst rvalid", cpu.cpu_rvalid, 0);
      check("rst err", cpu.cpu_err, 0);
      check("rst rdata", cpu.cpu_rdata, 0);
      check("rst reqs", {ram.ram_read_req, ram.ram_write_req}, 0);
      check("rst ram_addr", ram.ram_addr, 0);
      check("rst ram_wdata", ram.ram_wdata, 0);
      check("rst state", state_dbg, ST_INIT);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("uncal stall", cpu.cpu_stall, 1);
      check("uncal state", state_dbg, ST_INIT);
      ram.init_calib_complete = 1'b1;
      @(negedge clk);
      check("cal idle stall", cpu.cpu_stall, 0);

      // Directed table.
      for (int i = 0; i < 10; i++) begin
         exp_q.push_back({tv[i].x_err, tv[i].x_rvalid, tv[i].x_rdata});
         run_txn(tv[i], 1'b0, res);
         check_vec($sformatf("vec%0d", i), tv[i], res);
      end

      // Randomized transactions against the memory model.
      for (int i = 0; i < 40; i++) begin
         rvec.we    = 1'($urandom_range(0, 1));
         rvec.addr  = 32'h100 + 32'(4 * $urandom_range(0, 7));
         if ($urandom_range(0, 5) == 0) begin
            rvec.addr        = $urandom() & 32'hFFFF_FFFC;
            rvec.addr[31:29] = 3'($urandom_range(1, 7));
         end
         rvec.wdata  = $urandom();
         rvec.stall  = $urandom_range(0, 3);
         rvec.rdy    = $urandom_range(0, 3);
         rvec.lat    = $urandom_range(1, TO + 2);
         rvec.rd_val = 32'h0;
         hs = ((rvec.stall > rvec.rdy) ? rvec.stall : rvec.rdy) + 1;
         rvec.x_err = 1'b0; rvec.x_rvalid = 1'b0; rvec.x_rdata = 32'h0; rvec.x_hs = 1;
         if (rvec.addr[31:29] != 3'b000) begin
            rvec.x_end = 1; rvec.x_err = 1'b1; rvec.x_hs = 0;
         end else if (rvec.we) begin
            rvec.x_end = hs + 1;
            ref_mem[{3'b000, rvec.addr[28:0]}] = rvec.wdata;
         end else if (rvec.lat <= TO) begin
            rvec.x_end = hs + rvec.lat + 1; rvec.x_rvalid = 1'b1;
            rvec.x_rdata = ref_mem.exists({3'b000, rvec.addr[28:0]}) ?
                           ref_mem[{3'b000, rvec.addr[28:0]}] : init_word({3'b000, rvec.addr[28:0]});
         end else begin
            rvec.x_end = hs + TO + 1; rvec.x_err = 1'b1;
         end
         exp_q.push_back({rvec.x_err, rvec.x_rvalid, rvec.x_rdata});
         run_txn(rvec, 1'b1, res);
         check_vec($sformatf("rand%0d", i), rvec, res);
      end

      // Stray read data while idle must not reach the CPU.
      ram.ram_read_data_valid = 1'b1; ram.ram_read_data = 32'hFFFF_FFFF;
      @(negedge clk);
      ram.ram_read_data_valid = 1'b0;
      check("stray rvalid", cpu.cpu_rvalid, 0);
      check("stray stall", cpu.cpu_stall, 0);

      // Calibration lost while waiting for read data.
      cpu.cpu_en = 1'b1; cpu.cpu_we = 1'b0; cpu.cpu_addr = 32'h80;
      @(negedge clk);
      cpu.cpu_en = 1'b0;
      @(negedge clk);
      check("cal rd_wait", state_dbg, ST_RD_WAIT);
      ram.init_calib_complete = 1'b0;
      @(negedge clk);
      check("cal err", cpu.cpu_err, 1);
      check("cal stall", cpu.cpu_stall, 1);
      check("cal state", state_dbg, ST_INIT);
      ram.ram_read_data_valid = 1'b1; ram.ram_read_data = 32'h7777_7777;
      @(negedge clk);
      ram.ram_read_data_valid = 1'b0;
      check("cal err pulse", cpu.cpu_err, 0);
      check("cal late rvalid", cpu.cpu_rvalid, 0);
      check("cal still stalled", cpu.cpu_stall, 1);
      ram.init_calib_complete = 1'b1;
      @(negedge clk);
      check("recal stall", cpu.cpu_stall, 0);

      // Reset in the middle of a read drops it without an error.
      cpu.cpu_en = 1'b1; cpu.cpu_we = 1'b0; cpu.cpu_addr = 32'h84;
      @(negedge clk);
      cpu.cpu_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst state", state_dbg, ST_INIT);
      check("midrst rdata", cpu.cpu_rdata, 0);
      @(negedge clk);
      check("midrst err", cpu.cpu_err, 0);
      check("midrst stall", cpu.cpu_stall, 1);
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst idle", cpu.cpu_stall, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule

// File: doc/ram_req_bridge.md
RAM_REQ_BRIDGE -- requirements
Module: ram_req_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 4096, giving the maximum cycles in RD_WAIT before abort.
REQ-002 SHALL have parameter RAM_AW, default 29, giving the ram address width.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 cpu_en  input  1  CPU data request valid.
REQ-006 cpu_we  input  1  1 = write, 0 = read.
REQ-007 cpu_addr  input  32  byte address.
REQ-008 cpu_wdata  input  32  write data.
REQ-009 cpu_stall  output  1  CPU must hold its request and pipeline.
REQ-010 cpu_rdata  output  32  read data.
REQ-011 cpu_rvalid  output  1  single-cycle pulse: cpu_rdata is valid.
REQ-012 cpu_err  output  1  single-cycle pulse: request dropped or aborted.
REQ-013 ram_addr  output  RAM_AW  address to ram.
REQ-014 ram_wdata  output  32  write data to ram.
REQ-015 ram_read_req  output  1  read request to ram.
REQ-016 ram_write_req  output  1  write request to ram.
REQ-017 ram_write_ready, ram_read_ready  input  1 each  ram can accept that request type.
REQ-018 ram_stall  input  1  ram please_stall_everything.
REQ-019 ram_read_data_valid  input  1  ram read data is present.
REQ-020 ram_read_data  input  32  ram read data.
REQ-021 init_calib_complete  input  1  DDR3 calibration done.

Function
REQ-022 SHALL implement FSM states INIT, IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT.
REQ-023 In INIT: cpu_stall=1, no ram requests; move to IDLE on the cycle after init_calib_complete=1.
REQ-024 In IDLE: cpu_stall=0; accept when cpu_en=1; latch cpu_addr[RAM_AW-1:0], cpu_wdata, cpu_we into holding registers.
REQ-025 IDLE, accepted, cpu_addr[31:RAM_AW]!=0: cpu_err=1 next cycle; no ram request issued; remain IDLE.
REQ-026 IDLE, accepted, address in range: next state WR_ISSUE (cpu_we=1) or RD_ISSUE (cpu_we=0); cpu_stall=1 in every state except IDLE.
REQ-027 WR_ISSUE/RD_ISSUE: ram_addr, ram_wdata driven from the holding registers; ram_write_req or ram_read_req = ~ram_stall, combinational, held until handshake.
REQ-028 Handshake SHALL be the cycle where req=1, matching ready=1, and ram_stall=0; after it, WR_ISSUE goes to IDLE and RD_ISSUE goes to RD_WAIT.
REQ-029 In RD_WAIT: on ram_read_data_valid=1, register ram_read_data into cpu_rdata, pulse cpu_rvalid next cycle, go to IDLE.
REQ-030 RD_WAIT timeout counter SHALL start at 0 on entry; when it reaches TIMEOUT_CYCLES-1 with no valid: pulse cpu_err, set cpu_rdata=0, go to IDLE.
REQ-031 If ram_read_data_valid and timeout occur in the same cycle, valid SHALL win.
REQ-032 init_calib_complete=0 in any non-INIT state SHALL force INIT next cycle; if a request was pending (ISSUE/RD_WAIT), pulse cpu_err.
REQ-033 ram_read_data_valid outside RD_WAIT SHALL be ignored.
REQ-034 ram_read_req and ram_write_req SHALL never both be 1.
REQ-035 Throughput SHALL be at most one request in flight; minimum write latency accept-to-IDLE is 2 cycles.

Reset
REQ-036 On rst_n=0: state=INIT, cpu_stall=1, cpu_rvalid=0, cpu_err=0, cpu_rdata=0, ram_*_req=0, ram_addr=0, ram_wdata=0, timeout counter=0; reset mid-transaction drops it silently.

Structure
REQ-037 Package ram_bridge_pkg SHALL hold the FSM state enum and the default TIMEOUT_CYCLES and RAM_AW constants.
REQ-038 Single module; no sub-module (the timeout counter is inline).

Verification
REQ-039 Write accepted, ram ready and not stalled: cpu_addr=0x10, cpu_wdata=0xDEADBEEF -> ram_write_req one cycle with ram_addr=0x10 and ram_wdata=0xDEADBEEF; IDLE after 2 cycles.
REQ-040 Read of 0x40, ram_stall=1 for 5 cycles -> no req during stall, then one handshake; ram returns 0x12345678 after 7 cycles -> cpu_rvalid=1 with cpu_rdata=0x12345678.
REQ-041 cpu_addr=0x7000_0000 -> cpu_err pulse, no ram request, cpu_stall stays 0.
REQ-042 Read, never valid, TIMEOUT_CYCLES=16 -> cpu_err exactly 16 cycles after RD_WAIT entry, cpu_rdata=0.
REQ-043 init_calib_complete drops during RD_WAIT -> cpu_err pulse, state INIT, cpu_stall=1 until recalibration.
